// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_if
// Brief    : Request and instruction-write handshake bundle for instr_encoder.
// Revision : 1.0
// ============================================================================
interface instr_encoder_if #(
    parameter int ADDR_W = 10
) ();
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic              in_imm_sel;
    logic [3:0]        in_rdest;
    logic [3:0]        in_rsrc;
    logic [7:0]        in_imm;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [15:0]       out_instr;

    modport master (
        output in_valid, in_op, in_imm_sel, in_rdest, in_rsrc, in_imm, in_last, out_ready,
        input  in_ready, out_valid, out_addr, out_instr
    );

    modport slave (
        input  in_valid, in_op, in_imm_sel, in_rdest, in_rsrc, in_imm, in_last, out_ready,
        output in_ready, out_valid, out_addr, out_instr
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Encodes ALU requests into 16-bit instruction words with
//            sequential write addresses through a 2-entry output FIFO.
// Revision : 1.0
// ============================================================================
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    instr_encoder_if.slave    bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_fifo_addr  [2];
    logic [15:0]       r_fifo_instr [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic [1:0]        w_count_nxt;
    logic              r_err;
    logic [7:0]        r_err_count;

    logic              w_start_ok;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_legal;
    logic [3:0]        w_code;
    logic [15:0]       w_instr;

    assign bus.in_ready  = (r_state == S_ACTIVE) && (r_count != 2'd2);
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_addr  = r_fifo_addr[r_rd_ptr];
    assign bus.out_instr = r_fifo_instr[r_rd_ptr];

    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_accept   = bus.in_valid && bus.in_ready;
    assign w_push     = w_accept && w_legal;
    assign w_pop      = bus.out_valid && bus.out_ready;

    assign busy      = (r_state == S_ACTIVE) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;
    assign err_count = r_err_count;

    // Shared ALU code: used as ext in R-form and as opc in I-form.
    always_comb begin
        w_code = 4'b0000;
        case (bus.in_op)
            4'd0:    w_code = 4'b0101;
            4'd1:    w_code = 4'b1001;
            4'd2:    w_code = 4'b0001;
            4'd3:    w_code = 4'b0011;
            4'd4:    w_code = 4'b0010;
            4'd5:    w_code = 4'b1011;
            4'd6:    w_code = 4'b1101;
            default: w_code = 4'b0000;
        endcase
    end

    always_comb begin
        w_legal = 1'b1;
        w_instr = 16'h0000;
        case (bus.in_op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
                if (bus.in_imm_sel)
                    w_instr = {w_code, bus.in_rdest, bus.in_imm};
                else
                    w_instr = {4'b0000, bus.in_rdest, w_code, bus.in_rsrc};
            end
            4'd7: begin
                w_legal = !bus.in_imm_sel;
                w_instr = {4'b1000, bus.in_rdest, 4'b0100, bus.in_rsrc};
            end
            4'd8: begin
                w_legal = bus.in_imm_sel;
                w_instr = {4'b1000, bus.in_rdest, 4'b0000, bus.in_imm[3:0]};
            end
            4'd9: begin
                w_legal = bus.in_imm_sel;
                w_instr = {4'b1111, bus.in_rdest, bus.in_imm};
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 2'd1;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - 2'd1;
    end

    // DRAIN looks at next occupancy so done rises right after the final pop.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_accept && bus.in_last) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (w_count_nxt == 2'd0) w_state_nxt = S_DONE;
            S_DONE:   if (start) w_state_nxt = S_ACTIVE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_err           <= 1'b0;
            r_err_count     <= 8'd0;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_count         <= 2'd0;
            r_fifo_addr[0]  <= '0;
            r_fifo_addr[1]  <= '0;
            r_fifo_instr[0] <= 16'h0000;
            r_fifo_instr[1] <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_err   <= w_accept && !w_legal;

            if (w_start_ok)
                r_addr <= base_addr;
            else if (w_push)
                r_addr <= r_addr + ADDR_W'(1);

            if (w_start_ok)
                r_err_count <= 8'd0;
            else if (w_accept && !w_legal && (r_err_count != 8'hFF))
                r_err_count <= r_err_count + 8'd1;

            if (w_push) begin
                r_fifo_addr[r_wr_ptr]  <= r_addr;
                r_fifo_instr[r_wr_ptr] <= w_instr;
                r_wr_ptr               <= ~r_wr_ptr;
            end

            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
        end
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: ADDR_W, default 10, width of instruction-memory write address.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  one-cycle pulse; begins an encode session.
REQ-005 Port: base_addr  in  ADDR_W  first write address; sampled on accepted start.
REQ-006 Port: in_valid / in_ready  in / out  1 / 1  request handshake.
REQ-007 Port: in_op  in  4  ALU operation code: 0 add, 1 sub, 2 and, 3 xor, 4 or, 5 comp, 6 mov, 7 lsh, 8 lshi, 9 lui.
REQ-008 Port: in_imm_sel  in  1  1 = immediate form, 0 = register form.
REQ-009 Port: in_rdest, in_rsrc  in  4 each  destination and source register numbers.
REQ-010 Port: in_imm  in  8  immediate value.
REQ-011 Port: in_last  in  1  marks the final request of the session.
REQ-012 Port: out_valid / out_ready  out / in  1 / 1  instruction-write handshake.
REQ-013 Port: out_addr  out  ADDR_W  write address of the head word.
REQ-014 Port: out_instr  out  16  encoded instruction of the head word.
REQ-015 Port: busy  out  1  high in ACTIVE or DRAIN.
REQ-016 Port: done  out  1  high in DONE.
REQ-017 Port: err  out  1  one-cycle pulse per rejected request.
REQ-018 Port: err_count  out  8  count of rejected requests.

Function
REQ-019 Encoding SHALL use three formats:
- R-form: [15:12]=0000, [11:8]=rdest, [7:4]=ext, [3:0]=rsrc.
- I-form: [15:12]=opc, [11:8]=rdest, [7:0]=imm.
REQ-020 ext/opc codes for ops 0-6 SHALL be add 0101, sub 1001, and 0001, xor 0011, or 0010, comp 1011, mov 1101.
REQ-021 lsh (op 7) SHALL be register form only: [15:12]=1000, [11:8]=rdest, [7:4]=0100, [3:0]=rsrc.
REQ-022 lshi (op 8) SHALL be immediate form only: [15:12]=1000, [11:8]=rdest, [7:4]=0000, [3:0]=imm[3:0]; imm[7:4] is ignored.
REQ-023 lui (op 9) SHALL be immediate form only: [15:12]=1111, [11:8]=rdest, [7:0]=imm.
REQ-024 A request with op 10-15, op 7 with imm_sel=1, or op 8/9 with imm_sel=0 SHALL be rejected:
- nothing is written to the FIFO;
- the address is not advanced;
- err pulses in the following cycle;
- err_count increments, saturating at 255.
REQ-025 States SHALL be IDLE, ACTIVE, DRAIN and DONE.
- IDLE --start--> ACTIVE.
- ACTIVE --accepted in_last--> DRAIN; this applies even if that request is rejected.
- DRAIN --FIFO empty--> DONE.
- DONE --start--> ACTIVE.
- start is ignored in ACTIVE and DRAIN.
REQ-026 Accepting start SHALL load the address counter with base_addr and clear err_count.
REQ-027 in_ready SHALL equal (state==ACTIVE) AND (FIFO occupancy < 2); it is independent of in_valid.
REQ-028 Output buffer SHALL be a 2-entry FIFO of {addr, instr}; out_valid = occupancy != 0; out_addr/out_instr are the head entry.
REQ-029 Latency: a request accepted at edge N SHALL appear on out_valid after edge N when the FIFO was empty; there is no combinational path from in_* to out_*.
REQ-030 Pop on out_valid AND out_ready. Push and pop in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-031 The address counter SHALL increment by 1 per pushed word and wrap from 2^ADDR_W-1 to 0.
REQ-032 out_addr/out_instr SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-033 During reset SHALL apply: state=IDLE, FIFO flushed, out_valid=0, in_ready=0, busy=0, done=0, err=0, err_count=0, address counter=0, out_addr=0, out_instr=0.
REQ-034 Reset asserted mid-session SHALL discard all buffered words with no further out_valid until a new start.

Verification
REQ-035 base_addr=0x010, start; addi (op0, imm_sel=1, rdest=3, imm=0x2A) -> out_instr=0x532A, out_addr=0x010, one cycle after accept.
REQ-036 Register add rdest=2 rsrc=5 -> 0x0255; lsh rdest=1 rsrc=4 -> 0x8144; lshi rdest=6 imm=0xFF -> 0x860F; lui rdest=7 imm=0xAB -> 0xF7AB; consecutive addresses.
REQ-037 op=0xC, then lui with imm_sel=0 -> no out_valid, two err pulses, err_count=2, next valid word uses the unadvanced address.
REQ-038 out_ready=0 with 3 valid requests offered -> in_ready low after 2 accepts, head stable; out_ready=1 -> all 3 emitted in order, no loss or duplication.
REQ-039 base_addr=0x3FF, two requests, second with in_last -> addresses 0x3FF then 0x000; busy falls and done rises the cycle after the final pop.
REQ-040 reset while 2 words are buffered in ACTIVE -> next cycle out_valid=0, state IDLE, all outputs at reset values; in_valid ignored until start.
